ov7670_frame_ctrl: RTL and testbench
====================================

// Module: ov7670_frame_ctrl
// PURPOSE
//  Frame-level sequencer for the OV7670 + AL422 FIFO capture path. Gates camera writes into the
//  FIFO one whole frame at a time and hands the filled frame to the reader via READ_EN/RD_FRAME.
//  Write and read never overlap. Sits between the host/TX request logic and the FIFO reader.
// PARAMETERS
//  WRST_CYCLES     3          OV_WRST low-pulse length at frame start, clocks (>=1)
//  TIMEOUT_CYCLES  8_000_000  watchdog limit per wait state (200 ms @ 40 MHz)
//  CNT_W           16         FRAME_CNT width
// PORTS
//  CLK_40M      in   1      system clock, 40 MHz
//  RST_N        in   1      async active-low reset
//  OV_VSYNC     in   1      camera VSYNC, asynchronous to CLK_40M, active high
//  HOST_REQ     in   1      single-frame request, sampled in IDLE only
//  CONT_MODE    in   1      1 = capture back-to-back frames without HOST_REQ
//  ERR_CLR      in   1      clears TIMEOUT_ERR
//  RD_FRAME     in   1      from FIFO reader: 1 = idle/done, 0 = reading
//  OV_WEN       out  1      AL422 write enable, active high
//  OV_WRST      out  1      AL422 write-pointer reset, active low
//  READ_EN      out  1      read request to FIFO reader
//  BUSY         out  1      1 whenever state != IDLE
//  FRAME_DONE   out  1      1-cycle pulse when a frame read completes
//  FRAME_CNT    out  CNT_W  completed frames, wraps to 0
//  TIMEOUT_ERR  out  1      sticky watchdog flag
// BEHAVIOUR
//  Reset (async, immediate): OV_WEN=0, OV_WRST=1, READ_EN=0, BUSY=0, FRAME_DONE=0, FRAME_CNT=0,
//   TIMEOUT_ERR=0, state=IDLE, sync flops=0. Reset mid-frame abandons the frame. Nothing resumes.
//  VSYNC: 2-FF synchroniser, then an edge register. vs_rise is valid 3 clocks after the pin rises.
//   Falling edges are ignored.
//  FSM (all outputs registered):
//   IDLE:    HOST_REQ|CONT_MODE -> WAIT_VS. Otherwise stay.
//   WAIT_VS: vs_rise -> WRST. On entry to WRST: OV_WEN<=1, OV_WRST<=0.
//   WRST:    hold OV_WRST=0 for exactly WRST_CYCLES clocks, then OV_WRST<=1 -> CAPTURE.
//            vs_rise during WRST is ignored.
//   CAPTURE: OV_WEN=1. Next vs_rise -> OV_WEN<=0, READ_EN<=1 -> RD_REQ.
//   RD_REQ:  hold READ_EN=1 until RD_FRAME==0 is sampled, then READ_EN<=0 -> READING.
//   READING: RD_FRAME==1 sampled -> FRAME_DONE<=1 for 1 cycle, FRAME_CNT<=FRAME_CNT+1 -> IDLE.
//  CONT_MODE high: IDLE lasts one cycle, so each frame is followed immediately by WAIT_VS.
//   Every other camera frame is skipped while reading; this is intended.
//  HOST_REQ outside IDLE is ignored. Requests are not queued.
//  Invariant: OV_WEN and READ_EN are never 1 in the same cycle.
//   OV_WEN is 0 in every state except WRST and CAPTURE.
//  Watchdog: counter cleared on every state change. It counts in WAIT_VS, CAPTURE, RD_REQ and
//   READING. When it reaches TIMEOUT_CYCLES:
//    - TIMEOUT_ERR<=1, OV_WEN<=0, READ_EN<=0, OV_WRST<=1, next state IDLE;
//    - FRAME_CNT is unchanged and FRAME_DONE is not pulsed.
//   Counter width = $clog2(TIMEOUT_CYCLES+1). No wrap.
//  ERR_CLR clears TIMEOUT_ERR next cycle. If a timeout and ERR_CLR occur in the same cycle,
//   the timeout wins (flag stays 1). TIMEOUT_ERR does not block new requests.
//  FRAME_CNT wraps (2^CNT_W - 1) -> 0 silently.
//  A completion and a new request in the same cycle: completion is handled first. The request is
//   sampled the next cycle in IDLE.
// STRUCTURE
//  Shared package ov7670_pkg:
//   - state localparams IDLE/WAIT_VS/WRST/CAPTURE/RD_REQ/READING (3-bit);
//   - OV_FRAME_TIMEOUT_DEF;
//   - RD_FRAME idle level constant.
//  One sub-module: ov_vsync_sync (2-FF sync + rise-edge pulse, async active-low reset).
//  Remainder is a single FSM always block plus the watchdog counter.
// TESTING
//  1 Single shot, WRST_CYCLES=3: HOST_REQ pulse; VSYNC rises at t0 and t0+2000 clk.
//    -> OV_WRST low exactly 3 clk; OV_WEN high ~2000 clk; READ_EN rises the cycle OV_WEN falls.
//    -> With a reader model (RD_FRAME 0 one clk after READ_EN, 1 again 500 clk later):
//       FRAME_DONE 1-cycle pulse, FRAME_CNT=1, BUSY=0.
//  2 CONT_MODE=1, VSYNC period 1500 clk, reader busy 500 clk -> FRAME_CNT=3 after 3 read
//    completions; assert OV_WEN&READ_EN never both 1.
//  3 TIMEOUT_CYCLES=1000, HOST_REQ, no VSYNC -> TIMEOUT_ERR=1 exactly 1000 clk after WAIT_VS
//    entry, state IDLE, OV_WEN=0, OV_WRST=1.
//    ERR_CLR pulse -> TIMEOUT_ERR=0. ERR_CLR coincident with a timeout -> flag stays 1.
//  4 Reader model never drops RD_FRAME -> READ_EN held 1000 clk, then TIMEOUT_ERR=1, READ_EN=0,
//    FRAME_CNT unchanged.
//  5 RST_N low mid-CAPTURE (asynchronous to clock edge) -> all outputs at reset values before
//    the next clock edge. After release, no activity until HOST_REQ.
//  6 CNT_W=2, CONT_MODE, 5 frames -> FRAME_CNT 1,2,3,0,1. VSYNC glitch during WRST ignored.

Source files
------------

// File: rtl/ov7670_pkg.sv
// rtl/ov7670_pkg.sv - shared states and constants for the OV7670/AL422 frame sequencer
package ov7670_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_VS = 3'd1,
    WRST    = 3'd2,
    CAPTURE = 3'd3,
    RD_REQ  = 3'd4,
    READING = 3'd5
  } ov_state_e;

  // 200 ms at 40 MHz
  localparam int OV_FRAME_TIMEOUT_DEF = 8_000_000;

  // Level the FIFO reader drives on RD_FRAME when it is idle or has finished a frame
  localparam logic RD_FRAME_IDLE = 1'b1;

endpackage

// File: rtl/ov_vsync_sync.sv
// rtl/ov_vsync_sync.sv - two-flop VSYNC synchroniser with registered rising-edge pulse
module ov_vsync_sync (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic vsync_i,
  output logic vs_rise_o
);

  logic meta_q, sync_q, prev_q, rise_q;

  // Pulse is registered, so it appears three clocks after the pin rises
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      meta_q <= vsync_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      rise_q <= sync_q & ~prev_q;
    end
  end

  assign vs_rise_o = rise_q;

endmodule

// File: rtl/ov7670_frame_ctrl.sv
// rtl/ov7670_frame_ctrl.sv - frame-at-a-time write/read sequencer for the OV7670 + AL422 path
module ov7670_frame_ctrl
  import ov7670_pkg::*;
#(
  parameter int WRST_CYCLES    = 3,
  parameter int TIMEOUT_CYCLES = OV_FRAME_TIMEOUT_DEF,
  parameter int CNT_W          = 16
) (
  input  logic             CLK_40M,
  input  logic             RST_N,
  input  logic             OV_VSYNC,
  input  logic             HOST_REQ,
  input  logic             CONT_MODE,
  input  logic             ERR_CLR,
  input  logic             RD_FRAME,
  output logic             OV_WEN,
  output logic             OV_WRST,
  output logic             READ_EN,
  output logic             BUSY,
  output logic             FRAME_DONE,
  output logic [CNT_W-1:0] FRAME_CNT,
  output logic             TIMEOUT_ERR
);

  localparam int WCW = $clog2(WRST_CYCLES + 1);
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

  ov_state_e        state_q, state_d;
  logic             wen_q, wen_d;
  logic             wrst_q, wrst_d;
  logic             rden_q, rden_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [WCW-1:0]   wcnt_q, wcnt_d;
  logic [WDW-1:0]   wd_q, wd_d;
  logic             vs_rise;
  logic             wd_active;
  logic             timeout;

  ov_vsync_sync u_vsync_sync (
    .clk_i     (CLK_40M),
    .rst_n_i   (RST_N),
    .vsync_i   (OV_VSYNC),
    .vs_rise_o (vs_rise)
  );

  assign wd_active = (state_q == WAIT_VS) || (state_q == CAPTURE) ||
                     (state_q == RD_REQ)  || (state_q == READING);

  always_comb begin
    state_d = state_q;
    wen_d   = wen_q;
    wrst_d  = wrst_q;
    rden_d  = rden_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    err_d   = ERR_CLR ? 1'b0 : err_q;
    wcnt_d  = wcnt_q;
    wd_d    = wd_q;
    timeout = 1'b0;

    case (state_q)
      IDLE: begin
        if (HOST_REQ || CONT_MODE) state_d = WAIT_VS;
      end
      WAIT_VS: begin
        if (vs_rise) begin
          state_d = WRST;
          wen_d   = 1'b1;
          wrst_d  = 1'b0;
          wcnt_d  = '0;
        end
      end
      WRST: begin
        if (wcnt_q == WCW'(WRST_CYCLES - 1)) begin
          wrst_d  = 1'b1;
          state_d = CAPTURE;
        end else begin
          wcnt_d = wcnt_q + WCW'(1);
        end
      end
      CAPTURE: begin
        if (vs_rise) begin
          wen_d   = 1'b0;
          rden_d  = 1'b1;
          state_d = RD_REQ;
        end
      end
      RD_REQ: begin
        if (RD_FRAME != RD_FRAME_IDLE) begin
          rden_d  = 1'b0;
          state_d = READING;
        end
      end
      READING: begin
        if (RD_FRAME == RD_FRAME_IDLE) begin
          done_d  = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A genuine event on the watchdog's final cycle takes precedence over the timeout
    if (wd_active && (wd_q == WDW'(TIMEOUT_CYCLES - 1)) && (state_d == state_q)) begin
      timeout = 1'b1;
      err_d   = 1'b1;
      wen_d   = 1'b0;
      rden_d  = 1'b0;
      wrst_d  = 1'b1;
      state_d = IDLE;
    end

    if (state_d != state_q) wd_d = '0;
    else if (wd_active)     wd_d = wd_q + WDW'(1);

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK_40M or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      wen_q   <= 1'b0;
      wrst_q  <= 1'b1;
      rden_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      wcnt_q  <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      wen_q   <= wen_d;
      wrst_q  <= wrst_d;
      rden_q  <= rden_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      wcnt_q  <= wcnt_d;
      wd_q    <= wd_d;
    end
  end

  assign OV_WEN      = wen_q;
  assign OV_WRST     = wrst_q;
  assign READ_EN     = rden_q;
  assign BUSY        = busy_q;
  assign FRAME_DONE  = done_q;
  assign FRAME_CNT   = cnt_q;
  assign TIMEOUT_ERR = err_q;

endmodule

// File: tb/tb_ov7670_frame_ctrl.sv
// tb/tb_ov7670_frame_ctrl.sv - scoreboard bench for ov7670_frame_ctrl
module tb_ov7670_frame_ctrl;

  localparam int WRSTC = 3;
  localparam int TO    = 1000;
  localparam int CW    = 2;

  localparam int EV_WRST = 0;
  localparam int EV_WENF = 1;
  localparam int EV_DONE = 2;
  localparam int EV_TO   = 3;

  logic CLK_40M = 1'b0;
  logic RST_N = 1'b0, OV_VSYNC = 1'b0, HOST_REQ = 1'b0, CONT_MODE = 1'b0;
  logic ERR_CLR = 1'b0, RD_FRAME = 1'b1;
  logic OV_WEN, OV_WRST, READ_EN, BUSY, FRAME_DONE, TIMEOUT_ERR;
  logic [CW-1:0] FRAME_CNT;

  always #5 CLK_40M = ~CLK_40M;

  ov7670_frame_ctrl #(
    .WRST_CYCLES    (WRSTC),
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (CW)
  ) dut (
    .CLK_40M     (CLK_40M),
    .RST_N       (RST_N),
    .OV_VSYNC    (OV_VSYNC),
    .HOST_REQ    (HOST_REQ),
    .CONT_MODE   (CONT_MODE),
    .ERR_CLR     (ERR_CLR),
    .RD_FRAME    (RD_FRAME),
    .OV_WEN      (OV_WEN),
    .OV_WRST     (OV_WRST),
    .READ_EN     (READ_EN),
    .BUSY        (BUSY),
    .FRAME_DONE  (FRAME_DONE),
    .FRAME_CNT   (FRAME_CNT),
    .TIMEOUT_ERR (TIMEOUT_ERR)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // val: expected length/latency (-1 = don't care); aux: READ_EN level or latency reference
  typedef struct {
    int kind;
    int val;
    int aux;
    int cnt;
  } ev_t;

  ev_t exp_q[$];

  task automatic push(input int k, input int v, input int a, input int c);
    ev_t e;
    e.kind = k; e.val = v; e.aux = a; e.cnt = c;
    exp_q.push_back(e);
  endtask

  logic wrst_p = 1'b1, wen_p = 1'b0, busy_p = 1'b0, rden_p = 1'b0, err_p = 1'b0;
  int   wrst_len = 0, wen_len = 0, busy_age = 0, rden_age = 0;
  bit   inv_bad = 1'b0;
  bit   done_chk = 1'b0;

  task automatic got_event(input int k);
    ev_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_event", k, -1);
      return;
    end
    e = exp_q.pop_front();
    check("event_kind", k, e.kind);
    case (k)
      EV_WRST: check("wrst_low_len", wrst_len, e.val);
      EV_WENF: begin
        if (e.val >= 0) check("wen_high_len", wen_len, e.val);
        check("rden_at_wen_fall", int'(READ_EN), e.aux);
      end
      EV_DONE: begin
        check("done_frame_cnt", int'(FRAME_CNT), e.cnt);
        check("done_busy", int'(BUSY), 0);
      end
      default: begin
        check("timeout_latency", (e.aux != 0) ? rden_age : busy_age, e.val);
        check("timeout_frame_cnt", int'(FRAME_CNT), e.cnt);
        check("timeout_busy", int'(BUSY), 0);
        check("timeout_wen", int'(OV_WEN), 0);
        check("timeout_rden", int'(READ_EN), 0);
        check("timeout_wrst", int'(OV_WRST), 1);
        check("timeout_no_done", int'(FRAME_DONE), 0);
      end
    endcase
  endtask

  // Monitor: detects output events on the falling edge and scores them against the queue
  initial begin
    forever begin
      @(negedge CLK_40M);
      busy_age = (BUSY && !busy_p) ? 0 : busy_age + 1;
      rden_age = (READ_EN && !rden_p) ? 0 : rden_age + 1;
      if (done_chk) begin
        check("done_one_cycle", int'(FRAME_DONE), 0);
        done_chk = 1'b0;
      end
      if (OV_WEN && READ_EN) inv_bad = 1'b1;
      if (OV_WRST && !wrst_p) got_event(EV_WRST);
      if (!OV_WEN && wen_p) got_event(EV_WENF);
      if (FRAME_DONE) begin
        got_event(EV_DONE);
        done_chk = 1'b1;
      end
      if (TIMEOUT_ERR && !err_p) got_event(EV_TO);
      wrst_len = OV_WRST ? 0 : wrst_len + 1;
      wen_len  = OV_WEN ? wen_len + 1 : 0;
      wrst_p = OV_WRST; wen_p = OV_WEN; busy_p = BUSY; rden_p = READ_EN; err_p = TIMEOUT_ERR;
    end
  end

  // Reader model: drops RD_FRAME one clock after READ_EN, raises it rd_busy clocks later
  bit stuck   = 1'b0;
  int rd_busy = 500;

  initial begin
    forever begin
      @(negedge CLK_40M);
      if (READ_EN && !stuck) begin
        @(negedge CLK_40M);
        RD_FRAME = 1'b0;
        repeat (rd_busy) @(negedge CLK_40M);
        RD_FRAME = 1'b1;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "simulation time limit");
  end

  task automatic pulse_req();
    HOST_REQ = 1'b1;
    @(negedge CLK_40M);
    HOST_REQ = 1'b0;
  endtask

  task automatic pulse_clr();
    ERR_CLR = 1'b1;
    @(negedge CLK_40M);
    ERR_CLR = 1'b0;
  endtask

  // One VSYNC period starting with a rising edge; glitch adds a second rise two clocks in
  task automatic vs_frame(input int period, input bit glitch);
    OV_VSYNC = 1'b1;
    @(negedge CLK_40M);
    if (glitch) begin
      OV_VSYNC = 1'b0;
      @(negedge CLK_40M);
      OV_VSYNC = 1'b1;
      @(negedge CLK_40M);
      repeat (7) @(negedge CLK_40M);
    end else begin
      repeat (9) @(negedge CLK_40M);
    end
    OV_VSYNC = 1'b0;
    repeat (period - 10) @(negedge CLK_40M);
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (BUSY && n < max) begin
      @(negedge CLK_40M);
      n++;
    end
    check("wait_idle_busy", int'(BUSY), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wen"},  int'(OV_WEN), 0);
    check({tag, "_wrst"}, int'(OV_WRST), 1);
    check({tag, "_rden"}, int'(READ_EN), 0);
    check({tag, "_busy"}, int'(BUSY), 0);
    check({tag, "_done"}, int'(FRAME_DONE), 0);
    check({tag, "_cnt"},  int'(FRAME_CNT), 0);
    check({tag, "_err"},  int'(TIMEOUT_ERR), 0);
  endtask

  initial begin
    repeat (3) @(negedge CLK_40M);
    check_reset_outputs("reset");
    RST_N = 1'b1;
    @(negedge CLK_40M);

    // Single shot with reader
    rd_busy = 500;
    push(EV_WRST, WRSTC, 0, 0);
    push(EV_WENF, 600, 1, 0);
    push(EV_DONE, 0, 0, 1);
    pulse_req();
    repeat (5) @(negedge CLK_40M);
    vs_frame(600, 1'b0);
    vs_frame(600, 1'b0);
    wait_idle(2000);
    check("single_frame_cnt", int'(FRAME_CNT), 1);

    // Watchdog in WAIT_VS, then clear, then clear coincident with timeout
    push(EV_TO, TO, 0, 1);
    pulse_req();
    repeat (1005) @(negedge CLK_40M);
    check("to1_err", int'(TIMEOUT_ERR), 1);
    pulse_clr();
    check("err_clr", int'(TIMEOUT_ERR), 0);
    push(EV_TO, TO, 0, 1);
    pulse_req();
    repeat (999) @(negedge CLK_40M);
    ERR_CLR = 1'b1;
    @(negedge CLK_40M);
    ERR_CLR = 1'b0;
    check("clr_vs_timeout_err", int'(TIMEOUT_ERR), 1);
    @(negedge CLK_40M);
    check("clr_vs_timeout_err_hold", int'(TIMEOUT_ERR), 1);
    pulse_clr();
    check("err_clr2", int'(TIMEOUT_ERR), 0);

    // Reader never responds: READ_EN watchdog
    stuck = 1'b1;
    push(EV_WRST, WRSTC, 0, 0);
    push(EV_WENF, 300, 1, 0);
    push(EV_TO, TO, 1, 1);
    pulse_req();
    repeat (5) @(negedge CLK_40M);
    vs_frame(300, 1'b0);
    vs_frame(300, 1'b0);
    repeat (800) @(negedge CLK_40M);
    check("rd_to_err", int'(TIMEOUT_ERR), 1);
    check("rd_to_rden", int'(READ_EN), 0);
    check("rd_to_cnt", int'(FRAME_CNT), 1);
    stuck = 1'b0;
    pulse_clr();

    // Asynchronous reset in the middle of CAPTURE
    push(EV_WRST, WRSTC, 0, 0);
    push(EV_WENF, -1, 0, 0);
    pulse_req();
    repeat (5) @(negedge CLK_40M);
    vs_frame(100, 1'b0);
    check("pre_reset_wen", int'(OV_WEN), 1);
    @(posedge CLK_40M);
    #3 RST_N = 1'b0;
    #1 check_reset_outputs("async_rst");
    @(negedge CLK_40M);
    RST_N = 1'b1;
    vs_frame(50, 1'b0);
    repeat (20) @(negedge CLK_40M);
    check("post_reset_busy", int'(BUSY), 0);
    check("post_reset_wen", int'(OV_WEN), 0);
    check("post_reset_cnt", int'(FRAME_CNT), 0);

    // Continuous mode, 5 frames, counter wraps at 4, glitch during first WRST
    rd_busy = 300;
    for (int k = 1; k <= 5; k++) begin
      push(EV_WRST, WRSTC, 0, 0);
      push(EV_WENF, 700, 1, 0);
      push(EV_DONE, 0, 0, k % 4);
    end
    CONT_MODE = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 9) CONT_MODE = 1'b0;
      vs_frame(700, i == 0);
    end
    wait_idle(2000);
    check("cont_final_cnt", int'(FRAME_CNT), 1);
    repeat (5) @(negedge CLK_40M);

    check("events_left", exp_q.size(), 0);
    check("wen_rden_overlap", int'(inv_bad), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
